// File: rtl/multi_tick_timer_if.sv
// Control and tick bus for multi_tick_timer: run/channel configuration in, tick pulses and busy flags out.
// All outputs are registered single-cycle pulses (base_tick, ch_tick) or levels (ch_busy); no handshake back-pressure.
interface multi_tick_timer_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic                    enable;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       ch_mode;
  logic [NUM_CH-1:0]       ch_start;
  logic [NUM_CH*CNT_W-1:0] ch_period;
  logic                    base_tick;
  logic [NUM_CH-1:0]       ch_tick;
  logic [NUM_CH-1:0]       ch_busy;

  modport master (
    output enable, ch_en, ch_mode, ch_start, ch_period,
    input  base_tick, ch_tick, ch_busy
  );

  modport slave (
    input  enable, ch_en, ch_mode, ch_start, ch_period,
    output base_tick, ch_tick, ch_busy
  );
endinterface

// File: rtl/multi_tick_timer.sv
// Shared prescaler producing a base tick, plus NUM_CH channels dividing it by a
// programmable period in periodic or one-shot mode.
module multi_tick_timer #(
  parameter int PRESCALE = 25000,
  parameter int PRE_W    = 15,
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int RST_SYNC = 2
) (
  input  logic clock,
  input  logic reset,
  multi_tick_timer_if.slave bus
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [RST_SYNC-1:0] r_rst_chain;
  logic [PRE_W-1:0]    r_pre;
  logic                r_base_tick;
  logic                w_run;
  logic                w_pw;
  logic [NUM_CH-1:0]   w_tick;
  logic [NUM_CH-1:0]   w_armed;

  // Nothing counts until the release chain has filled with ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_rst_chain <= '0;
    else        r_rst_chain <= (r_rst_chain << 1) | RST_SYNC'(1);
  end

  assign w_run = r_rst_chain[RST_SYNC-1] & bus.enable;
  assign w_pw  = w_run & (r_pre == PRE_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pre       <= '0;
      r_base_tick <= 1'b0;
    end else begin
      r_base_tick <= w_pw;
      if (w_run) r_pre <= w_pw ? '0 : r_pre + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] w_period;
    logic             w_active;
    logic             w_expire;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_tick;

    assign w_period = bus.ch_period[g*CNT_W +: CNT_W];
    assign w_active = bus.ch_en[g] & (w_period != '0);
    // >= rather than == so a period lowered below the running count fires promptly.
    assign w_expire = (r_cnt >= (w_period - CNT_ONE));

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_cnt   <= '0;
        r_armed <= 1'b0;
        r_tick  <= 1'b0;
      end else begin
        r_tick <= 1'b0;
        if (!w_active) begin
          r_cnt   <= '0;
          r_armed <= 1'b0;
        end else if (w_run) begin
          if (bus.ch_start[g]) begin
            // Start beats a coincident expiry: restart the count, stay armed.
            r_cnt   <= '0;
            r_armed <= bus.ch_mode[g];
          end else if (!bus.ch_mode[g]) begin
            r_armed <= 1'b0;
            if (w_pw) begin
              if (w_expire) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end else if (r_armed && w_pw) begin
            if (w_expire) begin
              r_cnt   <= '0;
              r_tick  <= 1'b1;
              r_armed <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
      end
    end

    assign w_tick[g]  = r_tick;
    assign w_armed[g] = r_armed;
  end

  assign bus.base_tick = r_base_tick;
  assign bus.ch_tick   = w_tick;
  assign bus.ch_busy   = w_armed;

endmodule

// File: tb/tb_multi_tick_timer.sv
// Directed bench for multi_tick_timer with PRESCALE=4, RST_SYNC=2: expected tick
// events are queued with their cycle numbers and matched by a monitor.
module tb_multi_tick_timer;
  localparam int NC = 4;
  localparam int CW = 8;
  localparam int PS = 4;
  localparam int RS = 2;
  localparam int W  = 32 + 1 + NC;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0;
  int   t1;
  logic [W-1:0] exp_q[$];

  multi_tick_timer_if #(.NUM_CH(NC), .CNT_W(CW)) bus ();

  multi_tick_timer #(
    .PRESCALE(PS), .PRE_W(3), .NUM_CH(NC), .CNT_W(CW), .RST_SYNC(RS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int c, input logic b, input logic [NC-1:0] t);
    exp_q.push_back({32'(c), b, t});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_base"}, 32'(bus.base_tick), 32'd0);
    check({nm, "_tick"}, 32'(bus.ch_tick), 32'd0);
    check({nm, "_busy"}, 32'(bus.ch_busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    logic [NC-1:0] t;
    reset         = 1'b0;
    bus.enable    = 1'b1;
    bus.ch_en     = 4'b1111;
    bus.ch_mode   = 4'b0100;
    bus.ch_start  = 4'b0000;
    bus.ch_period = {8'd0, 8'd2, 8'd1, 8'd3};

    fork
      forever begin
        @(negedge clock);
        if (bus.base_tick || (bus.ch_tick != '0)) begin
          obs = {32'(cyc), bus.base_tick, bus.ch_tick};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected base %b tick %b at cycle %0d",
                     bus.base_tick, bus.ch_tick, cyc);
          end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
              errors++;
              $display("FAIL event: got cycle %0d base %b tick %b, expected cycle %0d base %b tick %b",
                       obs[W-1:NC+1], obs[NC], obs[NC-1:0], exp[W-1:NC+1], exp[NC], exp[NC-1:0]);
            end
          end
        end
      end
      begin
        #50000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
      end
    join_none

    repeat (3) @(negedge clock);
    check_idle("reset_state");

    // Segment A: ch0 P=3 periodic, ch1 P=1, ch2 one-shot P=2, ch3 P=0.
    t0 = cyc;
    for (int k = 1; k <= 20; k++) begin
      t[0] = (k == 3) || (k == 6) || (k == 9) || (k == 12) || (k == 16) || (k == 20);
      t[1] = 1'b1;
      t[2] = (k == 8) || (k == 20);
      t[3] = 1'b0;
      push_exp((k <= 9) ? (t0 + 2 + 4*k) : (t0 + 12 + 4*k), 1'b1, t);
    end
    reset = 1'b1;

    wait_until(t0 + 28); bus.ch_start = 4'b0100;
    wait_until(t0 + 29); bus.ch_start = 4'b0000;
    check("busy_armed", 32'(bus.ch_busy), 32'h4);
    wait_until(t0 + 33);
    check("busy_held", 32'(bus.ch_busy), 32'h4);
    wait_until(t0 + 34);
    check("busy_drop", 32'(bus.ch_busy), 32'h0);

    wait_until(t0 + 40); bus.enable = 1'b0;
    wait_until(t0 + 45);
    check("gap_base", 32'(bus.base_tick), 32'd0);
    wait_until(t0 + 50); bus.enable = 1'b1;

    wait_until(t0 + 60); bus.ch_period[7:0] = 8'd5;
    wait_until(t0 + 72); bus.ch_period[7:0] = 8'd2;

    wait_until(t0 + 78); bus.ch_start = 4'b0100;
    wait_until(t0 + 79); bus.ch_start = 4'b0000;
    wait_until(t0 + 83); bus.ch_start = 4'b0101;
    wait_until(t0 + 84); bus.ch_start = 4'b0000;
    check("busy_restart", 32'(bus.ch_busy), 32'h4);
    wait_until(t0 + 91);
    check("busy_before_exp", 32'(bus.ch_busy), 32'h4);

    wait_until(t0 + 92);
    check("pre_reset_base", 32'(bus.base_tick), 32'd1);
    #2 reset = 1'b0;
    #1 check_idle("async_reset");

    // Segment B: ch3 disabled with a nonzero period, fresh qualification.
    bus.ch_en = 4'b0111;
    bus.ch_period[31:24] = 8'd7;
    repeat (3) begin
      @(negedge clock);
      check_idle("held_reset");
    end
    t1 = cyc;
    for (int k = 1; k <= 4; k++) push_exp(t1 + 2 + 4*k, 1'b1, {2'b00, 1'b1, (k % 2 == 0)});
    reset = 1'b1;

    wait_until(t1 + 5);
    check("requal_base", 32'(bus.base_tick), 32'd0);
    wait_until(t1 + 20);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
